// File: rtl/bit_serial_adder_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial adder.
// The controller side (master) drives start/A/B/Cin; the adder side (slave) drives busy/done/Sum/Cout.
// Port V (signed overflow) exists only when OVERFLOW_FLAG_EN is defined.
interface bit_serial_adder_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef OVERFLOW_FLAG_EN
  logic             V;
`endif

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout
`ifdef OVERFLOW_FLAG_EN
    , input V
`endif
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout
`ifdef OVERFLOW_FLAG_EN
    , output V
`endif
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, operands consumed LSB first.
// Latency: start accepted on edge N -> busy cycles N+1..N+WIDTH -> done pulse in cycle N+WIDTH+1.
// Backpressure: start is only honoured in IDLE or DONE; it is ignored while busy (no queuing).
// Optional macro OVERFLOW_FLAG_EN adds the registered signed-overflow output V.
module bit_serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  bit_serial_adder_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef OVERFLOW_FLAG_EN
  logic             v_q;
`endif

  logic accept;
  logic last;
  logic fa_s;
  logic fa_c;
  logic busy_c;
  logic done_c;

  // start is only looked at when no add is in flight
  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
  assign last   = (state == SHIFT) && (cnt == LAST);

  // The single full-adder slice working on the current LSBs and the carry flop
  assign fa_s = a_sr[0] ^ b_sr[0] ^ carry_q;
  assign fa_c = (a_sr[0] & b_sr[0]) | (carry_q & (a_sr[0] ^ b_sr[0]));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      SHIFT:   busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  // Operand shift registers, partial result, carry flop and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sr    <= bus.A;
      b_sr    <= bus.B;
      carry_q <= bus.Cin;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= {fa_s, res_sr[WIDTH-1:1]};
      carry_q <= fa_c;
      // counter parks at WIDTH-1 instead of wrapping
      if (!last) cnt <= cnt + 1'b1;
    end
  end

  // Visible results change only when the last slice completes (DONE entry) or on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      v_q    <= 1'b0;
`endif
    end else if (last) begin
      sum_q  <= {fa_s, res_sr[WIDTH-1:1]};
      cout_q <= fa_c;
`ifdef OVERFLOW_FLAG_EN
      // carry_q holds the carry into the MSB slice during the last SHIFT cycle
      v_q    <= carry_q ^ fa_c;
`endif
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign bus.V    = v_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder (WIDTH=4) with a queue-based result scoreboard.
// Expected {Cout,Sum,V} come from an arithmetic model when each start is driven.
// Overflow checks are compiled in only when OVERFLOW_FLAG_EN is defined.
module tb_bit_serial_adder;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  bit_serial_adder_if #(.WIDTH(W)) bus ();

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: unsigned add plus signed overflow from carries into/out of the MSB
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0]   full;
    logic [W-1:0] low;
    exp_t e;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    low  = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, cin};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.v    = low[W-1] ^ full[W];
    sb.push_back(e);
  endtask

  // Called at a negedge; drives start for one cycle, then waits (bounded) for done.
  // glitch_at > 0 re-asserts start with all-ones operands in that busy cycle.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int glitch_at, input string tag);
    int   n;
    exp_t e;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    push_exp(a, b, cin);
    @(negedge clk);
    bus.start = 1'b0;
    for (n = 1; n <= 12; n++) begin
      if (bus.done === 1'b1) break;
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      check({tag, " sum hold"}, 32'({bus.Cout, bus.Sum}), 32'({prev_cout, prev_sum}));
      if (n == glitch_at) begin
        bus.start = 1'b1;
        bus.A     = '1;
        bus.B     = '1;
        bus.Cin   = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(W + 1));
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " busy in done"}, 32'(bus.busy), 32'd0);
    if (bus.done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " sum"}, 32'(bus.Sum), 32'(e.sum));
      check({tag, " cout"}, 32'(bus.Cout), 32'(e.cout));
`ifdef OVERFLOW_FLAG_EN
      check({tag, " v"}, 32'(bus.V), 32'(e.v));
`endif
      prev_sum  = e.sum;
      prev_cout = e.cout;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;

    // Reset for two cycles, then idle outputs must stay cleared
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset sum", 32'(bus.Sum), 32'd0);
      check("reset cout", 32'(bus.Cout), 32'd0);
    end

    // Basic add, then an idle cycle
    run_add(4'b0011, 4'b0101, 1'b0, 0, "add3+5");
    @(negedge clk);
    check("idle after done", 32'(bus.done), 32'd0);

    // Carry out, then back-to-back start issued in the DONE cycle
    run_add(4'b1111, 4'b0001, 1'b0, 0, "addF+1");
    run_add(4'b1111, 4'b1111, 1'b1, 0, "b2b F+F+1");
    @(negedge clk);
    check("single done pulse", 32'(bus.done), 32'd0);
    check("idle busy", 32'(bus.busy), 32'd0);

    // start pulsed during SHIFT must be ignored
    run_add(4'b0010, 4'b0010, 1'b0, 2, "ignore start");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no extra done", 32'(bus.done), 32'd0);
      check("no extra busy", 32'(bus.busy), 32'd0);
    end

    // Reset in the second SHIFT cycle aborts the add and clears the results
    bus.start = 1'b1;
    bus.A     = 4'b0111;
    bus.B     = 4'b0111;
    bus.Cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort busy1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("abort busy2", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort sum", 32'(bus.Sum), 32'd0);
    check("abort cout", 32'(bus.Cout), 32'd0);
    prev_sum  = '0;
    prev_cout = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort no done", 32'(bus.done), 32'd0);
    end

    // Recovery after the abort
    run_add(4'b1010, 4'b0110, 1'b1, 0, "recover");
    @(negedge clk);

`ifdef OVERFLOW_FLAG_EN
    run_add(4'b0111, 4'b0001, 1'b0, 0, "ovf 7+1");
    @(negedge clk);
    run_add(4'b1000, 4'b1111, 1'b0, 0, "ovf 8+F");
    @(negedge clk);
    run_add(4'b0101, 4'b1101, 1'b0, 0, "ovf 5+D");
    @(negedge clk);
`endif

    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
